// File: rtl/peripheral_bus_register_responder_if.sv
// Internal peripheral bus: the bridge drives the master side and each register block answers on the slave side.
interface peripheral_bus_register_responder_if;
  logic        we;
  logic        oe;
  logic        busy;
  logic [23:0] address;
  logic [3:0]  byteSelect;
  logic [31:0] dataWrite;
  logic [31:0] dataRead;

  modport master (
    output we, oe, address, byteSelect, dataWrite,
    input  busy, dataRead
  );

  modport slave (
    input  we, oe, address, byteSelect, dataWrite,
    output busy, dataRead
  );
endinterface

// File: rtl/peripheral_bus_register_responder.sv
// Register bank responder: decodes an address window, serves 32-bit registers with byte writes,
// programmable wait states and one-cycle access strobes for the surrounding peripheral logic.
module peripheral_bus_register_responder #(
  parameter logic [23:0]          ADDRESS_BASE   = 24'h000000,
  parameter int unsigned          ADDRESS_BITS   = 8,
  parameter int unsigned          REG_COUNT      = 4,
  parameter int unsigned          WAIT_STATES    = 1,
  parameter logic [REG_COUNT-1:0] READ_ONLY_MASK = '0
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  peripheral_bus_register_responder_if.slave peripheralBus,
  output logic [32*REG_COUNT-1:0]    hw_regOut,
  input  logic [32*REG_COUNT-1:0]    hw_regIn,
  output logic [REG_COUNT-1:0]       reg_writeStrobe,
  output logic [REG_COUNT-1:0]       reg_readStrobe
);

  localparam int unsigned IDX_W = ADDRESS_BITS - 2;

  typedef enum logic {
    S_COUNT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [31:0]      regs [REG_COUNT];

  logic             access;
  logic             selected;
  logic             in_range;
  logic             active;
  logic             complete;
  logic             is_read;
  logic [IDX_W-1:0] idx;

  // Address decode and access qualification; reset masks the whole handshake.
  always_comb begin
    access   = peripheralBus.we | peripheralBus.oe;
    selected = access &&
               (peripheralBus.address[23:ADDRESS_BITS] == ADDRESS_BASE[23:ADDRESS_BITS]);
    idx      = peripheralBus.address[ADDRESS_BITS-1:2];
    in_range = 32'(idx) < REG_COUNT;
    is_read  = peripheralBus.oe && !peripheralBus.we;
    active   = selected && (state_q == S_COUNT) && !wb_rst_i;
    complete = active && (wait_q == 4'(WAIT_STATES));
    peripheralBus.busy = active && (wait_q < 4'(WAIT_STATES));
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_COUNT;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Dropping we/oe rearms the responder; the done state blocks a second commit on a held access.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (!access) begin
      state_d = S_COUNT;
      wait_d  = '0;
    end else if (active) begin
      if (complete) begin
        state_d = S_DONE;
      end else begin
        wait_d = wait_q + 4'd1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        regs[i] <= '0;
      end
      reg_writeStrobe <= '0;
    end else begin
      reg_writeStrobe <= '0;
      if (complete && peripheralBus.we && in_range) begin
        for (int i = 0; i < int'(REG_COUNT); i++) begin
          if (idx == IDX_W'(i)) begin
            reg_writeStrobe[i] <= 1'b1;
            if (!READ_ONLY_MASK[i]) begin
              for (int b = 0; b < 4; b++) begin
                if (peripheralBus.byteSelect[b]) begin
                  regs[i][8*b +: 8] <= peripheralBus.dataWrite[8*b +: 8];
                end
              end
            end
          end
        end
      end
    end
  end

  // Read mux drives zero when not addressed so responders can be OR-combined.
  always_comb begin
    peripheralBus.dataRead = '0;
    reg_readStrobe         = '0;
    for (int i = 0; i < int'(REG_COUNT); i++) begin
      if (selected && is_read && !wb_rst_i && (idx == IDX_W'(i))) begin
        peripheralBus.dataRead = READ_ONLY_MASK[i] ? hw_regIn[32*i +: 32] : regs[i];
        reg_readStrobe[i]      = complete;
      end
    end
  end

  for (genvar g = 0; g < int'(REG_COUNT); g++) begin : g_reg_out
    assign hw_regOut[32*g +: 32] = regs[g];
  end

endmodule
